mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/internal_defines_pkg.sv | 19 +
 rtl/mem_port_arbiter_reg.sv | 27 ++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/internal_defines_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, grant
// identity and the default access timeout.
`timescale 1ns/1ps
package internal_defines;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/mem_port_arbiter_reg.sv
// Generic load-enable register with asynchronous active-low clear, used to
// hold the address/data/mask presented to memory for the whole access.
`timescale 1ns/1ps
module mem_port_arbiter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] value_q;

    // Capture the input when enabled, otherwise hold
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            value_q <= '0;
        end else if (en_i) begin
            value_q <= d_i;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master memory port arbiter: instruction fetch and data requesters
// share one memory port. Ties are broken round-robin, a stalled access is
// completed with an error after TIMEOUT_CYC cycles, and halt stops new grants.
`timescale 1ns/1ps
module mem_port_arbiter
    import internal_defines::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    input  logic        d_req,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] rdata,
    output logic        err,
    input  logic        halt,
    output logic        idle,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        mem_excpt
);

    // The counter holds the number of stalled BUSY cycles so far; the access
    // times out in the BUSY cycle whose increment would reach TIMEOUT_CYC-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 2);

    arb_state_e  state_q, state_d;
    logic [7:0]  count_q, count_d;
    grant_e      lastGrant_q, lastGrant_d;
    logic        ifDone_q, ifDone_d;
    logic        dDone_q, dDone_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        grantIf, grantData;
    logic [65:0] memLatch_d, memLatch_q;

    // State, counter, round-robin flag and completion outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            lastGrant_q <= GRANT_DATA;
            ifDone_q    <= 1'b0;
            dDone_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lastGrant_q <= lastGrant_d;
            ifDone_q    <= ifDone_d;
            dDone_q     <= dDone_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Grant selection, access tracking and completion/timeout decisions
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lastGrant_d = lastGrant_q;
        ifDone_d    = 1'b0;
        dDone_d     = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        grantIf     = 1'b0;
        grantData   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!halt && rst_b) begin
                    if (if_req && (!d_req || lastGrant_q == GRANT_DATA)) begin
                        grantIf     = 1'b1;
                        state_d     = ST_BUSY_I;
                        lastGrant_d = GRANT_FETCH;
                        count_d     = '0;
                    end else if (d_req) begin
                        grantData   = 1'b1;
                        state_d     = ST_BUSY_D;
                        lastGrant_d = GRANT_DATA;
                        count_d     = '0;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ready) begin
                    rdata_d  = mem_rdata;
                    err_d    = mem_excpt;
                    ifDone_d = (state_q == ST_BUSY_I);
                    dDone_d  = (state_q == ST_BUSY_D);
                    state_d  = ST_IDLE;
                    count_d  = '0;
                end else if (count_q == TIMEOUT_LAST) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    ifDone_d = (state_q == ST_BUSY_I);
                    dDone_d  = (state_q == ST_BUSY_D);
                    state_d  = ST_IDLE;
                    count_d  = '0;
                end else begin
                    count_d  = count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        memLatch_d = grantData ? {d_addr, d_wdata, d_we}
                               : {if_addr, 32'd0, 4'd0};
    end

    mem_port_arbiter_reg #(
        .WIDTH (66)
    ) uMemLatch (
        .clk   (clk),
        .rst_b (rst_b),
        .en_i  (grantIf | grantData),
        .d_i   (memLatch_d),
        .q_o   (memLatch_q)
    );

    assign if_gnt    = grantIf;
    assign d_gnt     = grantData;
    assign if_done   = ifDone_q;
    assign d_done    = dDone_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign idle      = (state_q == ST_IDLE);
    assign mem_req   = (state_q != ST_IDLE);
    assign mem_addr  = memLatch_q[65:36];
    assign mem_wdata = memLatch_q[35:4];
    assign mem_we    = memLatch_q[3:0];

endmodule
